r5p_lsu: RTL and testbench

- Load/store unit directly downstream of the ALU. It consumes the ALU adder output (`sum`) as the effective address and `rs2` as store data.
- It runs one data-bus transaction per memory instruction and returns aligned, sign- or zero-extended load data to writeback.
- It stalls the core while a transaction is outstanding and flags misaligned accesses without touching the bus.

---
 rtl/r5p_lsu.sv | 156 +++++++++++++++
 tb/tb_r5p_lsu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/r5p_lsu.sv
// Load/store unit: one data-bus transaction per memory instruction, returning
// aligned and extended load data, with misalignment detected before the bus.
module r5p_lsu #(
  parameter int XLEN = 32,
  parameter int BW   = XLEN/8
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            ctl_vld,
  input  logic            ctl_we,
  input  logic [1:0]      ctl_sz,
  input  logic            ctl_uns,
  input  logic [XLEN-1:0] adr,
  input  logic [XLEN-1:0] wdt,
  output logic [XLEN-1:0] rdt,
  output logic            done,
  output logic            stall,
  output logic            mal,
  output logic            bus_vld,
  output logic            bus_wen,
  output logic [XLEN-1:0] bus_adr,
  output logic [BW-1:0]   bus_ben,
  output logic [XLEN-1:0] bus_wdt,
  input  logic            bus_rdy,
  input  logic [XLEN-1:0] bus_rdt
);

  localparam int OW = $clog2(BW);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   off, off_r;
  logic [1:0]      sz_r;
  logic            uns_r;
  logic            req, mis, issue;
  logic [BW-1:0]   ben_base, ben_c;
  logic [XLEN-1:0] wdt_c, sh, ld;
  logic            sgn;
  int              nb;

  assign off = adr[OW-1:0];
  // Combinational outputs stay quiet while reset is held.
  assign req = ctl_vld & rst;

  always_comb begin
    unique case (ctl_sz)
      2'b00:   mis = 1'b0;
      2'b01:   mis = adr[0];
      2'b10:   mis = |adr[1:0];
      default: mis = (XLEN == 32) ? 1'b1 : |adr[2:0];
    endcase
  end

  assign issue = (state == IDLE) && req && !mis;

  always_comb begin
    unique case (ctl_sz)
      2'b00:   ben_base = BW'(1);
      2'b01:   ben_base = BW'(3);
      2'b10:   ben_base = BW'(15);
      default: ben_base = '1;
    endcase
    ben_c = ben_base << off;
  end

  // Replicate store data so the addressed lane carries it regardless of offset.
  always_comb begin
    unique case (ctl_sz)
      2'b00:   wdt_c = {BW{wdt[7:0]}};
      2'b01:   wdt_c = {(BW/2){wdt[15:0]}};
      2'b10:   wdt_c = {(XLEN/32){wdt[31:0]}};
      default: wdt_c = wdt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bus_vld <= 1'b0;
      bus_wen <= 1'b0;
      bus_adr <= '0;
      bus_ben <= '0;
      bus_wdt <= '0;
      off_r   <= '0;
      sz_r    <= '0;
      uns_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        bus_vld <= 1'b1;
        bus_wen <= ctl_we;
        bus_adr <= {adr[XLEN-1:OW], {OW{1'b0}}};
        bus_ben <= ben_c;
        bus_wdt <= wdt_c;
        off_r   <= off;
        sz_r    <= ctl_sz;
        uns_r   <= ctl_uns;
      end else if (state == REQ && bus_rdy) begin
        bus_vld <= 1'b0;
      end
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (mis) done = 1'b1;
          else     state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus_rdy) begin
          if (bus_wen) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RSP;
          end
        end
      end
      RSP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend above the access width.
  assign sh = bus_rdt >> {off_r, 3'b000};

  always_comb begin
    unique case (sz_r)
      2'b00:   begin nb = 8;    sgn = sh[7];      end
      2'b01:   begin nb = 16;   sgn = sh[15];     end
      2'b10:   begin nb = 32;   sgn = sh[31];     end
      default: begin nb = XLEN; sgn = sh[XLEN-1]; end
    endcase
    for (int i = 0; i < XLEN; i++) begin
      ld[i] = (i < nb) ? sh[i] : (sgn & ~uns_r);
    end
  end

  assign rdt   = (state == RSP) ? ld : '0;
  assign mal   = (state == IDLE) && req && mis;
  assign stall = ctl_vld & ~done;

endmodule

// File: tb/tb_r5p_lsu.sv
// Randomized scoreboard bench for r5p_lsu: a byte-level reference model
// predicts bus payload, load results and stall length for every instruction.
module tb_r5p_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctl_vld, ctl_we, ctl_uns;
  logic [1:0]  ctl_sz;
  logic [31:0] adr, wdt, rdt, bus_adr, bus_wdt, bus_rdt;
  logic        done, stall, mal, bus_vld, bus_wen, bus_rdy;
  logic [3:0]  bus_ben;

  r5p_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ctl_vld(ctl_vld), .ctl_we(ctl_we), .ctl_sz(ctl_sz),
    .ctl_uns(ctl_uns), .adr(adr), .wdt(wdt), .rdt(rdt), .done(done),
    .stall(stall), .mal(mal), .bus_vld(bus_vld), .bus_wen(bus_wen),
    .bus_adr(bus_adr), .bus_ben(bus_ben), .bus_wdt(bus_wdt),
    .bus_rdy(bus_rdy), .bus_rdt(bus_rdt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mal;
    bit          we;
    logic [31:0] badr;
    logic [3:0]  ben;
    logic [31:0] bwdt;
    logic [31:0] rdt;
    int          stall;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          failures = 0;
  int          hs_cnt = 0;
  int          exp_hs = 0;
  int          wait_plan = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic finish_up();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Reference model: memory seen as bytes; an access of nb bytes at offset off.
  function automatic exp_t model(bit we, logic [1:0] sz, bit uns,
                                 logic [31:0] a, logic [31:0] d,
                                 logic [31:0] r, int waits);
    exp_t e;
    int nb  = 1 << sz;
    int off = a % 4;
    e.we   = we;
    e.mal  = (sz == 2'd3) || (a % nb != 0);
    e.badr = a - off;
    e.ben  = '0;
    e.bwdt = '0;
    e.rdt  = '0;
    for (int b = 0; b < 4; b++) begin
      e.ben[b] = (b >= off) && (b < off + nb);
      e.bwdt[8*b +: 8] = d[8*(b % nb) +: 8];
    end
    if (!we && !e.mal) begin
      for (int i = 0; i < nb; i++) e.rdt[8*i +: 8] = r[8*(off+i) +: 8];
      if (!uns && nb < 4 && r[8*(off+nb)-1]) e.rdt = e.rdt | (32'hFFFF_FFFF << (8*nb));
    end
    e.stall = e.mal ? 0 : (we ? 1 : 2) + waits;
    return e;
  endfunction

  task automatic drive(bit we, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] d);
    ctl_vld = 1'b1; ctl_we = we; ctl_sz = sz; ctl_uns = uns; adr = a; wdt = d;
  endtask

  // Issue one instruction (caller is at posedge+1) and hold it until done.
  task automatic run(bit we, logic [1:0] sz, bit uns, logic [31:0] a,
                     logic [31:0] d, logic [31:0] r, int waits);
    exp_t e;
    int n;
    e = model(we, sz, uns, a, d, r, waits);
    exp_q.push_back(e);
    if (!we && !e.mal) rd_q.push_back(r);
    if (!e.mal) exp_hs++;
    wait_plan = waits;
    drive(we, sz, uns, a, d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) begin
      check("done_timeout", 64'(done), 64'd1);
      finish_up();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int cycles);
    ctl_vld = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  // Bus slave: planned wait states, read data one cycle after a load handshake.
  initial begin
    bit hs;
    int wait_cnt;
    bus_rdy = 1'b0;
    bus_rdt = '0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      hs = rst && bus_vld && bus_rdy && !bus_wen;
      @(posedge clk); #1;
      if (hs && rd_q.size() > 0) bus_rdt = rd_q.pop_front();
      else                       bus_rdt = $urandom;
      if (!bus_vld) begin
        wait_cnt = 0;
        bus_rdy  = 1'($urandom_range(0, 1));
      end else if (wait_cnt < wait_plan) begin
        wait_cnt++;
        bus_rdy = 1'b0;
      end else begin
        bus_rdy = 1'b1;
      end
    end
  end

  // Monitor: compares bus payload against the head entry, pops on done.
  initial begin
    exp_t e;
    int stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_cnt = 0;
        continue;
      end
      if (stall) stall_cnt++;
      check("stall_rule", 64'(stall), 64'(ctl_vld & ~done));
      if (!ctl_vld) begin
        check("idle_done", 64'(done), 64'd0);
        check("idle_mal", 64'(mal), 64'd0);
      end
      if (bus_vld) begin
        if (exp_q.size() == 0) begin
          check("bus_orphan", 64'(bus_vld), 64'd0);
        end else begin
          e = exp_q[0];
          check("vld_on_mal", 64'(e.mal), 64'd0);
          check("bus_wen", 64'(bus_wen), 64'(e.we));
          check("bus_adr", 64'(bus_adr), 64'(e.badr));
          check("bus_ben", 64'(bus_ben), 64'(e.ben));
          if (e.we) check("bus_wdt", 64'(bus_wdt), 64'(e.bwdt));
          if (bus_rdy) hs_cnt++;
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_orphan", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("mal", 64'(mal), 64'(e.mal));
          check("rdt", 64'(rdt), 64'(e.rdt));
          check("stall_len", 64'(stall_cnt), 64'(e.stall));
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    int h0;
    exp_t e;
    rst = 1'b0;
    ctl_vld = 1'b0; ctl_we = 1'b0; ctl_sz = '0; ctl_uns = 1'b0; adr = '0; wdt = '0;
    #12;
    check("rst_bus_vld", 64'(bus_vld), 64'd0);
    check("rst_bus_wen", 64'(bus_wen), 64'd0);
    check("rst_bus_adr", 64'(bus_adr), 64'd0);
    check("rst_bus_ben", 64'(bus_ben), 64'd0);
    check("rst_bus_wdt", 64'(bus_wdt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mal", 64'(mal), 64'd0);
    check("rst_rdt", 64'(rdt), 64'd0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    run(1, 2'd0, 0, 32'h1003, 32'h0000_00AB, 32'h0, 0);
    idle(1);
    run(0, 2'd1, 0, 32'h2002, 32'h0, 32'h8001_1234, 0);
    run(0, 2'd1, 1, 32'h2002, 32'h0, 32'h8001_1234, 0);
    run(0, 2'd2, 0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 3);
    idle(1);
    run(0, 2'd2, 0, 32'h1002, 32'h0, 32'h0, 0);
    idle(1);

    // Reset while a request waits for the bus.
    e = model(1, 2'd2, 0, 32'h500, 32'h1122_3344, 32'h0, 50);
    exp_q.push_back(e);
    wait_plan = 50;
    drive(1, 2'd2, 0, 32'h500, 32'h1122_3344);
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_rst_vld", 64'(bus_vld), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_vld", 64'(bus_vld), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    ctl_vld = 1'b0;
    exp_q.delete();
    rd_q.delete();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    run(1, 2'd1, 0, 32'h602, 32'h0000_BEEF, 32'h0, 0);
    idle(1);

    // Back-to-back store then load.
    h0 = hs_cnt;
    run(1, 2'd1, 0, 32'h3002, 32'h0000_1234, 32'h0, 0);
    run(0, 2'd0, 1, 32'h3001, 32'h0, 32'h0000_FF00, 0);
    idle(1);
    check("b2b_handshakes", 64'(hs_cnt - h0), 64'd2);

    for (int i = 0; i < 300; i++) begin
      bit          we  = 1'($urandom_range(0, 1));
      logic [1:0]  sz  = 2'($urandom_range(0, 3));
      bit          uns = 1'($urandom_range(0, 1));
      logic [31:0] a   = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run(we, sz, uns, a, $urandom, $urandom, $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    check("handshake_total", 64'(hs_cnt), 64'(exp_hs));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    finish_up();
  end

  initial begin
    #500000;
    check("global_timeout", 64'd1, 64'd0);
    finish_up();
  end

endmodule
